// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM duty path: duty width, full-scale value, ramp states.
// Latency: none (types, constants and a combinational helper only).
// Backpressure: not applicable.
package pwm_pkg;

  localparam int DC_W = 7;
  localparam logic [DC_W-1:0] DC_MAX = 7'd100;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RAMP = 1'b1
  } state_t;

  // Saturate a requested duty cycle to full scale (100 percent).
  function automatic logic [DC_W-1:0] clamp_dc(input logic [DC_W-1:0] v);
    return (v > DC_MAX) ? DC_MAX : v;
  endfunction

endpackage

// File: rtl/pwm_period_tick.sv
// Free-running PWM period counter; pulses period_tick on the last clock of each period.
// Latency: period_tick is decoded combinationally from the registered counter.
// Backpressure: none; the counter never stalls, so consumers stay phase-aligned.
module pwm_period_tick #(
  parameter int PERIOD_CLKS = 256
) (
  input  logic clk,
  input  logic reset,
  output logic period_tick
);

  localparam int CNT_W = (PERIOD_CLKS > 2) ? $clog2(PERIOD_CLKS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD_CLKS - 1);

  logic [CNT_W-1:0] cnt;

  // Count 0..PERIOD_CLKS-1 and wrap, independent of any enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign period_tick = (cnt == LAST);

endmodule

// File: rtl/pwm_duty_ramp.sv
// Soft-start/slew stage: walks dc toward an accepted target in bounded steps on period boundaries.
// Latency: first step lands one clock after the HOLD_PERIODS-th period_tick following an accept.
// Backpressure: tgt_ready is high whenever out of reset; a new target may replace one mid-ramp.
module pwm_duty_ramp
  import pwm_pkg::*;
#(
  parameter int PERIOD_CLKS  = 256,
  parameter int STEP         = 1,
  parameter int HOLD_PERIODS = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [DC_W-1:0] tgt_dc,
  input  logic            tgt_valid,
  output logic            tgt_ready,
  input  logic            enable,
  output logic [DC_W-1:0] dc,
  output logic            busy,
  output logic            done,
  output logic            period_tick
);

  localparam int HOLD_W = (HOLD_PERIODS > 2) ? $clog2(HOLD_PERIODS) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_PERIODS - 1);
  localparam logic [7:0] STEP8 = 8'(STEP);

  state_t            state;
  logic [DC_W-1:0]   target;
  logic [HOLD_W-1:0] hold;

  logic              accept;
  logic              ramp_tick;
  logic              step_due;
  logic [DC_W-1:0]   tgt_clamped;
  logic [DC_W-1:0]   dc_next;
  logic [7:0]        dc8;
  logic [7:0]        tgt8;
  logic [7:0]        gap8;
  logic [7:0]        inc8;

  pwm_period_tick #(
    .PERIOD_CLKS(PERIOD_CLKS)
  ) u_period_tick (
    .clk        (clk),
    .reset      (reset),
    .period_tick(period_tick)
  );

  assign accept      = tgt_valid && tgt_ready;
  assign tgt_clamped = clamp_dc(tgt_dc);
  // Only ticks seen while ramping and enabled advance the hold count.
  assign ramp_tick   = (state == RAMP) && enable && period_tick;
  assign step_due    = ramp_tick && (hold == HOLD_LAST);

  // Next duty value: move by at most STEP toward the target, never past it.
  always_comb begin
    dc8     = {1'b0, dc};
    tgt8    = {1'b0, target};
    gap8    = (dc8 < tgt8) ? (tgt8 - dc8) : (dc8 - tgt8);
    inc8    = (gap8 < STEP8) ? gap8 : STEP8;
    dc_next = (dc8 < tgt8) ? DC_W'(dc8 + inc8) : DC_W'(dc8 - inc8);
  end

  // Accept/ramp control; an accept takes priority over a coincident step.
  always_ff @(posedge clk) begin
    if (reset) begin
      dc        <= '0;
      target    <= '0;
      hold      <= '0;
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      tgt_ready <= 1'b0;
    end else begin
      tgt_ready <= 1'b1;
      done      <= 1'b0;
      if (accept) begin
        target <= tgt_clamped;
        hold   <= '0;
        if (tgt_clamped == dc) begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else begin
          state <= RAMP;
          busy  <= 1'b1;
        end
      end else if (ramp_tick) begin
        if (step_due) begin
          hold <= '0;
          dc   <= dc_next;
          if (dc_next == target) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end else begin
          hold <= hold + HOLD_W'(1);
        end
      end
    end
  end

endmodule
